// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Instruction Fetch stage of the five-stage pipeline. Holds the fetch PC,
//   issues word reads to instruction memory, buffers the returned words in a
//   small in-order queue and hands them to decode with a valid/ready handshake.
//   A branch redirect flushes the queue and discards every response that was
//   still in flight when the redirect happened.
//
// Ports
//   clock, reset        : single clock, synchronous active-high reset
//   out_Mem_req/addr    : read request toward instruction memory (word aligned)
//   in_Mem_ready        : memory accepts the request this cycle
//   in_Mem_valid/data   : in-order read response, at most one per cycle
//   in_Branch_taken     : redirect strobe from a later stage
//   in_Branch_target    : redirect address (low two bits ignored)
//   out_Instr_valid     : queue head valid toward decode
//   in_Instr_ready      : decode accepts the head
//   out_Instruction     : queue head instruction word
//   out_Instr_pc        : address of out_Instruction
//   out_Pc_plus8        : out_Instr_pc + 8 (architectural R15 read value)
// -----------------------------------------------------------------------------
`ifndef WordWidth
`define WordWidth 32
`endif
`ifndef InstructionWidth
`define InstructionWidth 32
`endif

module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  output logic                           out_Mem_req,
  output logic [`WordWidth-1:0]          out_Mem_addr,
  input  logic                           in_Mem_ready,
  input  logic                           in_Mem_valid,
  input  logic [`InstructionWidth-1:0]   in_Mem_data,
  input  logic                           in_Branch_taken,
  input  logic [`WordWidth-1:0]          in_Branch_target,
  output logic                           out_Instr_valid,
  input  logic                           in_Instr_ready,
  output logic [`InstructionWidth-1:0]   out_Instruction,
  output logic [`WordWidth-1:0]          out_Instr_pc,
  output logic [`WordWidth-1:0]          out_Pc_plus8
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0]  MAX_OUT     = 2'(MAX_OUTSTANDING);
  localparam logic [CW:0] DEPTH_SLOTS = (CW+1)'(QUEUE_DEPTH);

  logic [`WordWidth-1:0]        pc;
  logic [1:0]                   outstanding;
  logic [1:0]                   outstanding_next;
  logic [1:0]                   drop;

  logic [`InstructionWidth-1:0] instr_q [QUEUE_DEPTH];
  logic [`WordWidth-1:0]        pc_q    [QUEUE_DEPTH];
  logic [PW-1:0]                rd_ptr;
  logic [PW-1:0]                wr_ptr;
  logic [CW-1:0]                count;

  // Addresses of accepted requests in issue order; the oldest entry names the
  // next response. Four slots always cover the outstanding limit of three.
  logic [`WordWidth-1:0]        slot_pc [4];
  logic [1:0]                   slot_wr;
  logic [1:0]                   slot_rd;

  logic                         accept;
  logic                         push;
  logic                         pop;
  logic [CW:0]                  used_slots;
  logic                         unused_target_bits;

  assign unused_target_bits = ^in_Branch_target[1:0];

  // Every outstanding request reserves a queue entry so a response always
  // has room when it arrives.
  assign used_slots  = {1'b0, count} + (CW+1)'(outstanding);
  assign out_Mem_req = !reset && !in_Branch_taken &&
                       (outstanding < MAX_OUT) && (used_slots < DEPTH_SLOTS);
  assign out_Mem_addr = pc;
  assign accept = out_Mem_req && in_Mem_ready;

  // A response is kept only when no stale requests remain ahead of it and no
  // redirect is flushing the queue in this same cycle.
  assign push = in_Mem_valid && (drop == 2'd0) && !in_Branch_taken;
  assign pop  = out_Instr_valid && in_Instr_ready && !in_Branch_taken;

  assign out_Instr_valid = (count != '0);
  assign out_Instruction = instr_q[rd_ptr];
  assign out_Instr_pc    = pc_q[rd_ptr];
  assign out_Pc_plus8    = pc_q[rd_ptr] + 32'd8;

  always_comb begin
    outstanding_next = outstanding;
    case ({accept, in_Mem_valid})
      2'b10:   outstanding_next = outstanding + 2'd1;
      2'b01:   outstanding_next = outstanding - 2'd1;
      default: outstanding_next = outstanding;
    endcase
  end

  // On a redirect the drop counter is loaded with whatever is still in flight
  // after this cycle's response retires, so later stale responses are
  // discarded; reloading it on a back-to-back redirect keeps that true.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_VECTOR;
      outstanding <= 2'd0;
      drop        <= 2'd0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      slot_wr     <= 2'd0;
      slot_rd     <= 2'd0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        slot_pc[i] <= '0;
      end
    end else begin
      outstanding <= outstanding_next;
      if (accept) begin
        slot_pc[slot_wr] <= pc;
        slot_wr          <= slot_wr + 2'd1;
      end
      if (in_Mem_valid) begin
        slot_rd <= slot_rd + 2'd1;
      end
      if (in_Branch_taken) begin
        pc     <= {in_Branch_target[31:2], 2'b00};
        drop   <= outstanding_next;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept) begin
          pc <= pc + 32'd4;
        end
        if (in_Mem_valid && (drop != 2'd0)) begin
          drop <= drop - 2'd1;
        end
        if (push) begin
          instr_q[wr_ptr] <= in_Mem_data;
          pc_q[wr_ptr]    <= slot_pc[slot_rd];
          wr_ptr          <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Memory must never answer when nothing is outstanding.
  always_ff @(posedge clock) begin
    if (!reset && in_Mem_valid) begin
      assert (outstanding != 2'd0);
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Randomised bench for instruction_fetch. A memory model answers accepted
//   requests in order after a random delay; a transaction-level model tags
//   every request with a redirect epoch, drops any response from an older
//   epoch, and keeps the list of instructions decode must see in order.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam int QUEUE_DEPTH     = 4;
  localparam int MAX_OUTSTANDING = 2;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clock;
  logic        reset;
  logic        out_Mem_req;
  logic [31:0] out_Mem_addr;
  logic        in_Mem_ready;
  logic        in_Mem_valid;
  logic [31:0] in_Mem_data;
  logic        in_Branch_taken;
  logic [31:0] in_Branch_target;
  logic        out_Instr_valid;
  logic        in_Instr_ready;
  logic [31:0] out_Instruction;
  logic [31:0] out_Instr_pc;
  logic [31:0] out_Pc_plus8;

  int tests;
  int fails;

  req_t        pending[$];
  ent_t        exp_q[$];
  logic [31:0] model_pc;
  int          epoch;
  int          cycle;
  int          last_due;
  bit          model_req;

  int          ready_pct;
  int          dec_pct;
  int          branch_pct;
  int          dmin;
  int          dmax;
  bit          force_branch;
  logic [31:0] force_target;

  logic        obs_req;
  logic [31:0] obs_addr;
  logic        obs_valid;
  logic [31:0] obs_pc;
  logic [31:0] obs_plus8;

  instruction_fetch #(
    .RESET_VECTOR(RESET_VECTOR),
    .QUEUE_DEPTH(QUEUE_DEPTH),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .clock(clock),
    .reset(reset),
    .out_Mem_req(out_Mem_req),
    .out_Mem_addr(out_Mem_addr),
    .in_Mem_ready(in_Mem_ready),
    .in_Mem_valid(in_Mem_valid),
    .in_Mem_data(in_Mem_data),
    .in_Branch_taken(in_Branch_taken),
    .in_Branch_target(in_Branch_target),
    .out_Instr_valid(out_Instr_valid),
    .in_Instr_ready(in_Instr_ready),
    .out_Instruction(out_Instruction),
    .out_Instr_pc(out_Instr_pc),
    .out_Pc_plus8(out_Pc_plus8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic modelReset();
    pending.delete();
    exp_q.delete();
    model_pc = RESET_VECTOR;
    epoch++;
    cycle    = 0;
    last_due = -1;
  endtask

  // Holds reset across two rising edges while memory throws junk responses at
  // the block, then checks every output sits at its reset value.
  task automatic doReset();
    @(negedge clock);
    reset            = 1'b1;
    in_Mem_valid     = 1'b1;
    in_Mem_data      = $urandom;
    in_Mem_ready     = 1'b1;
    in_Branch_taken  = 1'b0;
    in_Branch_target = $urandom;
    in_Instr_ready   = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #1;
    check32("reset_req",   {31'd0, out_Mem_req},     32'd0);
    check32("reset_valid", {31'd0, out_Instr_valid}, 32'd0);
    check32("reset_instr", out_Instruction,          32'd0);
    check32("reset_pc",    out_Instr_pc,             32'd0);
    check32("reset_plus8", out_Pc_plus8,             32'd8);
    modelReset();
  endtask

  task automatic applyStimulus();
    @(negedge clock);
    reset          = 1'b0;
    in_Mem_ready   = ($urandom_range(0, 99) < ready_pct);
    in_Instr_ready = ($urandom_range(0, 99) < dec_pct);
    if (force_branch) begin
      in_Branch_taken  = 1'b1;
      in_Branch_target = force_target;
      force_branch     = 1'b0;
    end else begin
      in_Branch_taken  = ($urandom_range(0, 99) < branch_pct);
      in_Branch_target = $urandom;
    end
    if (pending.size() > 0 && pending[0].due <= cycle) begin
      in_Mem_valid = 1'b1;
      in_Mem_data  = memWord(pending[0].addr);
    end else begin
      in_Mem_valid = 1'b0;
      in_Mem_data  = $urandom;
    end
  endtask

  task automatic checkOutput();
    model_req = !in_Branch_taken && (pending.size() < MAX_OUTSTANDING) &&
                (pending.size() + exp_q.size() < QUEUE_DEPTH);
    obs_req   = out_Mem_req;
    obs_addr  = out_Mem_addr;
    obs_valid = out_Instr_valid;
    obs_pc    = out_Instr_pc;
    obs_plus8 = out_Pc_plus8;
    check32("mem_req",     {31'd0, out_Mem_req},     {31'd0, model_req});
    check32("mem_addr",    out_Mem_addr,             model_pc);
    check32("instr_valid", {31'd0, out_Instr_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check32("instruction", out_Instruction, exp_q[0].instr);
      check32("instr_pc",    out_Instr_pc,    exp_q[0].pc);
      check32("pc_plus8",    out_Pc_plus8,    exp_q[0].pc + 32'd8);
    end
  endtask

  task automatic updateModel();
    req_t r;
    bit   stale;
    int   d;
    stale = 1'b1;
    if (in_Mem_valid && pending.size() > 0) begin
      r     = pending.pop_front();
      stale = in_Branch_taken || (r.epoch != epoch);
    end
    if (!in_Branch_taken && exp_q.size() > 0 && in_Instr_ready) begin
      void'(exp_q.pop_front());
    end
    if (in_Mem_valid && !stale) begin
      exp_q.push_back('{memWord(r.addr), r.addr});
    end
    if (in_Branch_taken) begin
      exp_q.delete();
      epoch++;
      model_pc = {in_Branch_target[31:2], 2'b00};
    end else if (model_req && in_Mem_ready) begin
      d = cycle + 1 + int'($urandom_range(dmin, dmax));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pending.push_back('{model_pc, epoch, d});
      model_pc = model_pc + 32'd4;
    end
    cycle++;
  endtask

  task automatic step();
    applyStimulus();
    #1;
    checkOutput();
    updateModel();
  endtask

  task automatic setKnobs(input int rp, input int dp, input int bp, input int lo, input int hi);
    ready_pct  = rp;
    dec_pct    = dp;
    branch_pct = bp;
    dmin       = lo;
    dmax       = hi;
  endtask

  // Runs until decode sees a valid head, bounded, and pins its address.
  task automatic expectFirstPc(input string name, input logic [31:0] pc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (obs_valid) begin
        seen = 1'b1;
        check32(name, obs_pc, pc);
      end
    end
    if (!seen) check32({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    epoch = 0;
    force_branch     = 1'b0;
    force_target     = '0;
    reset            = 1'b1;
    in_Mem_ready     = 1'b0;
    in_Mem_valid     = 1'b0;
    in_Mem_data      = '0;
    in_Branch_taken  = 1'b0;
    in_Branch_target = '0;
    in_Instr_ready   = 1'b0;
    setKnobs(100, 100, 0, 0, 0);

    // Zero-wait memory, decode always ready: back-to-back delivery.
    doReset();
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) begin
        check32("first_req",  {31'd0, obs_req}, 32'd1);
        check32("first_addr", obs_addr, RESET_VECTOR);
      end
      if (k == 1) check32("valid_c2", {31'd0, obs_valid}, 32'd0);
      if (k == 2) begin
        check32("valid_c3", {31'd0, obs_valid}, 32'd1);
        check32("pc_c3",    obs_pc,    32'h0);
        check32("p8_c3",    obs_plus8, 32'h8);
      end
      if (k == 3) check32("p8_c4", obs_plus8, 32'hC);
      if (k == 4) check32("pc_c5", obs_pc, 32'h8);
    end

    // Decode stalled: queue fills with four entries and fetch stops.
    doReset();
    setKnobs(100, 0, 0, 0, 0);
    repeat (10) step();
    check32("stall_req", {31'd0, obs_req}, 32'd0);
    check32("stall_pc",  obs_pc, 32'h0);
    setKnobs(100, 100, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check32("drain_pc", obs_pc, 32'(4 * k));
      if (k == 1) check32("resume_addr", obs_addr, 32'h10);
    end

    // Memory not ready for five cycles.
    setKnobs(0, 100, 0, 0, 0);
    repeat (5) step();

    // Redirect with responses two cycles behind the requests.
    doReset();
    setKnobs(100, 100, 0, 1, 1);
    repeat (3) step();
    force_branch = 1'b1;
    force_target = 32'h0000_1003;
    step();
    step();
    check32("redir_valid", {31'd0, obs_valid}, 32'd0);
    check32("redir_addr",  obs_addr, 32'h0000_1000);
    expectFirstPc("redir_first_pc", 32'h0000_1000);

    // Two redirects close together: nothing stale may leak through.
    repeat (2) step();
    force_branch = 1'b1;
    force_target = 32'h0000_2000;
    step();
    step();
    force_branch = 1'b1;
    force_target = 32'h0000_3002;
    step();
    expectFirstPc("redir2_first_pc", 32'h0000_3000);

    // Address wrap at the top of the address space.
    setKnobs(100, 100, 0, 0, 0);
    force_branch = 1'b1;
    force_target = 32'hFFFF_FFFE;
    step();
    step();
    check32("wrap_req",  {31'd0, obs_req}, 32'd1);
    check32("wrap_top",  obs_addr, 32'hFFFF_FFFC);
    step();
    check32("wrap_zero", obs_addr, 32'h0000_0000);

    // Reset with requests in flight.
    setKnobs(100, 100, 0, 2, 2);
    repeat (3) step();
    doReset();
    step();
    check32("post_reset_req",  {31'd0, obs_req}, 32'd1);
    check32("post_reset_addr", obs_addr, RESET_VECTOR);

    // Randomised traffic.
    for (int blk = 0; blk < 15; blk++) begin
      setKnobs(int'($urandom_range(30, 100)), int'($urandom_range(20, 100)),
               int'($urandom_range(0, 8)), 0, int'($urandom_range(0, 4)));
      repeat (200) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
